vx_fifo_share_arb: RTL and testbench
====================================

# vx_fifo_share_arb

Shares one `VX_fifo_queue` among `NUM_REQS` push requesters. A round-robin arbiter grants at most one push per cycle and caps each requester's in-flight entries so no requester can monopolise the queue. Every entry is tagged with its requester ID and drained through one valid/ready output. The block sits between per-lane producers (for example warp or bank request lanes) and a single downstream consumer.

## Interface
- `NUM_REQS`, 4: number of requesters, ≥2.
- `DATAW`, 32: payload width.
- `SIZE`, 16: queue depth, power of 2, ≥2.
- `MAX_PER_REQ`, `SIZE/2`: per-requester in-flight cap, 1..`SIZE`.
- `OUT_REG`, 0: passed to the queue instance.
- `REQW`, `$clog2(NUM_REQS)`: ID width.
- `SIZEW`, `$clog2(SIZE+1)`: count width.
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `NUM_REQS`: per-requester push request.
- `req_data`, in, `NUM_REQS*DATAW`: payload; requester i uses bits [i*DATAW +: DATAW].
- `req_ready`, out, `NUM_REQS`: one-hot-or-zero grant.
- `out_valid`, out, 1: head entry available.
- `out_data`, out, `DATAW`: head payload.
- `out_id`, out, `REQW`: requester that pushed the head entry.
- `out_ready`, in, 1: consumer accepts the head entry.
- `req_count`, out, `NUM_REQS*SIZEW`: entries in flight per requester.
- `size`, out, `SIZEW`: total queue occupancy.

## Operation
- Eligibility: requester i is eligible when `req_valid[i]`, `req_count[i] != MAX_PER_REQ`, and the queue is not full.
- Full blocks all grants, even when a pop happens in the same cycle. There is no full-pop bypass.
- Arbitration: round-robin starting at `rr_ptr`. The lowest index ≥ `rr_ptr` wins; the search wraps modulo `NUM_REQS`. `req_ready` is purely combinational from the eligibility logic and registered state.
- Grant: `push` = |`req_ready`. The queue writes {grant_id, req_data[grant_id]}. `rr_ptr` <= grant_id+1, wrapping to 0 after `NUM_REQS-1`. `rr_ptr` is unchanged on cycles with no grant.
- Drain: `out_valid` = !queue empty. `pop` = `out_valid & out_ready`. `out_data` and `out_id` are the head fields.
- Counters: `req_count[grant_id]` +1 on grant, and `req_count[out_id]` −1 on pop. If the same ID is granted and popped in one cycle, its count is unchanged. Counts saturate by construction; an increment past the cap or a decrement below 0 is an assertion failure.
- Invariant: Σ`req_count` == `size` every cycle (assert).
- Reset (asynchronous): `rr_ptr`, all counters and the gate flop clear immediately.
  - `req_ready`, `out_valid`, `req_count` and `size` read 0 while `reset` is high.
  - The queue instance receives `reset` directly and needs at least one `clk` edge during reset, because its reset is synchronous.
  - A gate flop (async-cleared, set on the first edge after release) forces `req_ready` and `out_valid` low until the queue is known clean.
- Reset mid-operation: all queued entries are discarded and counts return to 0. No pop is reported for the discarded entries.

## Timing
- Grant-to-visibility: an entry granted in cycle t pushes at edge t+1. It can first appear at `out_valid` in cycle t+1, with either `OUT_REG` value.
- Throughput: 1 push and 1 pop per cycle sustained.
- `req_count` and `size` are registered and update at the edge that completes the push or pop.
- Cap release: a pop at edge t makes that requester eligible again in cycle t+1.
- `size` equals the queue's `size` output.

## Structure
- Package `vx_fifo_share_pkg` holds the entry struct typedef {id [REQW], data [DATAW]} and the `rr_next` pointer-wrap function.
- The natural sub-module is `VX_fifo_queue`, instantiated once with `DATAW = REQW+DATAW`.
- The round-robin pick stays inline: a rotate, a priority encode, then an unrotate.

## Test plan
- Single requester: `req_valid`=0001 for 3 cycles, `out_ready`=1 → pushes A,B,C; `out_id`=0 in order; `req_count[0]` peaks at 1.
- Fairness: `req_valid`=1111 continuously, `out_ready`=1 → grant order 0,1,2,3,0,…; no requester is granted twice within 4 consecutive grants.
- Cap: `NUM_REQS`=4, `SIZE`=16, `MAX_PER_REQ`=8, `out_ready`=0, only requester 2 valid → 8 grants, then `req_ready[2]`=0 with `size`=8; one pop of an ID-2 entry → regranted the next cycle.
- Full: all requesters valid, `out_ready`=0 → `size` reaches 16 and all `req_ready`=0; assert `out_ready` → still no grant in the pop cycle, grant in the cycle after.
- Same-ID push+pop: `req_count[1]`=3, head `out_id`=1, grant 1 and pop in the same cycle → `req_count[1]` stays 3 and `size` is unchanged.
- Mid-run reset: `size`=5, assert `reset` asynchronously between edges → `out_valid`=0, `req_ready`=0 and all counts 0 immediately; after release and one edge, normal grants resume with `rr_ptr`=0.

Source files
------------

// File: rtl/vx_fifo_share_pkg.sv
// Shared types and helpers for the shared-FIFO push arbiter.
package vx_fifo_share_pkg;

  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_DATAW    = 32;
  localparam int DEF_SIZE     = 16;
  localparam int DEF_REQW     = $clog2(DEF_NUM_REQS);

  // Queue entry layout: requester tag above the payload.
  typedef struct packed {
    logic [DEF_REQW-1:0]  id;
    logic [DEF_DATAW-1:0] data;
  } share_entry_t;

  // Round-robin pointer advance: one past the winner, wrapping at num.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned num);
    return (id + 32'd1 >= num) ? 32'd0 : id + 32'd1;
  endfunction

endpackage

// File: rtl/VX_fifo_queue.sv
// Power-of-two circular FIFO with first-word-fall-through head and synchronous reset.
// OUT_REG != 0 presents the head from a register instead of straight from the array.
module VX_fifo_queue #(
  parameter int DATAW   = 32,
  parameter int SIZE    = 16,
  parameter int OUT_REG = 0,
  localparam int ADDRW  = $clog2(SIZE),
  localparam int SIZEW  = $clog2(SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [DATAW-1:0] data_i,
  output logic [DATAW-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [SIZEW-1:0] size_o
);

  logic [DATAW-1:0] mem_q [SIZE];
  logic [ADDRW-1:0] rd_ptr_q, wr_ptr_q;
  logic [SIZEW-1:0] size_q;

  // Storage write; no reset so the array maps onto RAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      size_q   <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + ADDRW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + ADDRW'(1);
      size_q <= size_q + SIZEW'(push_i) - SIZEW'(pop_i);
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [ADDRW-1:0] rd_next;
      logic [DATAW-1:0] head_q, head_d;
      // Next head is the incoming word when it lands exactly at the new read slot.
      always_comb begin
        rd_next = rd_ptr_q + ADDRW'(pop_i);
        head_d  = (push_i && (wr_ptr_q == rd_next)) ? data_i : mem_q[rd_next];
      end
      // Registered head copy.
      always_ff @(posedge clk) begin
        head_q <= head_d;
      end
      assign data_o = head_q;
    end else begin : g_out_comb
      assign data_o = mem_q[rd_ptr_q];
    end
  endgenerate

  assign empty_o = (size_q == '0);
  assign full_o  = (size_q == SIZEW'(SIZE));
  assign size_o  = size_q;

endmodule

// File: rtl/vx_fifo_share_arb.sv
// Round-robin push arbiter sharing one FIFO among NUM_REQS producers, with a
// per-requester in-flight cap and requester-tagged output entries.
import vx_fifo_share_pkg::*;

module vx_fifo_share_arb #(
  parameter int NUM_REQS    = DEF_NUM_REQS,
  parameter int DATAW       = DEF_DATAW,
  parameter int SIZE        = DEF_SIZE,
  parameter int MAX_PER_REQ = SIZE / 2,
  parameter int OUT_REG     = 0,
  parameter int REQW        = $clog2(NUM_REQS),
  parameter int SIZEW       = $clog2(SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [REQW-1:0]           out_id,
  input  logic                      out_ready,
  output logic [NUM_REQS*SIZEW-1:0] req_count,
  output logic [SIZEW-1:0]          size
);

  // Same layout as share_entry_t, sized by this instance's parameters.
  typedef struct packed {
    logic [REQW-1:0]  id;
    logic [DATAW-1:0] data;
  } entry_t;

  logic [REQW-1:0]       rr_ptr_q;
  logic                  gate_q;
  logic [NUM_REQS-1:0]   elig;
  logic [2*NUM_REQS-1:0] elig_dbl;
  logic [NUM_REQS-1:0]   elig_rot;
  logic [REQW:0]         enc, grant_sum;
  logic [REQW-1:0]       grant_id;
  logic                  grant_any;
  logic                  push, pop;
  logic                  q_empty, q_full;
  logic [SIZEW-1:0]      q_size;
  entry_t                q_din, q_dout;

  // Gate holds the outputs quiet until the queue has seen a clocked reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gate_q <= 1'b0;
    else       gate_q <= 1'b1;
  end

  // Rotate so rr_ptr sits at bit 0, pick lowest set bit, rotate the index back.
  always_comb begin
    elig_dbl  = {elig, elig} >> rr_ptr_q;
    elig_rot  = elig_dbl[NUM_REQS-1:0];
    enc       = '0;
    for (int i = NUM_REQS - 1; i >= 0; i--) begin
      if (elig_rot[i]) enc = (REQW+1)'(i);
    end
    grant_sum = enc + {1'b0, rr_ptr_q};
    if (grant_sum >= (REQW+1)'(NUM_REQS)) grant_sum = grant_sum - (REQW+1)'(NUM_REQS);
    grant_id  = grant_sum[REQW-1:0];
    grant_any = |elig;
    req_ready = grant_any ? (NUM_REQS'(1) << grant_id) : '0;
  end

  // Pointer moves one past the winner; held when nobody is granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     rr_ptr_q <= '0;
    else if (push) rr_ptr_q <= REQW'(rr_next(32'(grant_id), NUM_REQS));
  end

  assign push       = |req_ready;
  assign pop        = out_valid & out_ready;
  assign q_din.id   = grant_id;
  assign q_din.data = req_data[grant_id*DATAW +: DATAW];

  generate
    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_req
      logic [SIZEW-1:0] cnt_q;
      logic             inc, dec;

      // Full blocks every grant, even when a pop frees a slot this cycle.
      assign elig[gi] = gate_q && req_valid[gi] && !q_full
                        && (cnt_q != SIZEW'(MAX_PER_REQ));
      assign inc = push && (grant_id == REQW'(gi));
      assign dec = pop && (q_dout.id == REQW'(gi));

      // In-flight count; a same-cycle grant and pop of this ID cancel out.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_q + SIZEW'(inc) - SIZEW'(dec);
      end

      assign req_count[gi*SIZEW +: SIZEW] = cnt_q;

`ifndef SYNTHESIS
      // Count must never step past the cap or below zero.
      always @(posedge clk) begin
        if (!reset && gate_q) begin
          assert (!(inc && !dec && cnt_q == SIZEW'(MAX_PER_REQ)));
          assert (!(dec && !inc && cnt_q == '0));
        end
      end
`endif
    end
  endgenerate

  VX_fifo_queue #(
    .DATAW   (REQW + DATAW),
    .SIZE    (SIZE),
    .OUT_REG (OUT_REG)
  ) queue_inst (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (q_din),
    .data_o  (q_dout),
    .empty_o (q_empty),
    .full_o  (q_full),
    .size_o  (q_size)
  );

  assign out_valid = gate_q & ~q_empty;
  assign out_data  = q_dout.data;
  assign out_id    = q_dout.id;
  assign size      = gate_q ? q_size : '0;

`ifndef SYNTHESIS
  logic [SIZEW+REQW-1:0] count_sum;

  // Total of per-requester counts.
  always_comb begin
    count_sum = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      count_sum = count_sum + {{REQW{1'b0}}, req_count[i*SIZEW +: SIZEW]};
    end
  end

  // Per-requester bookkeeping must add up to the queue occupancy.
  always @(posedge clk) begin
    if (!reset && gate_q) assert (count_sum == {{REQW{1'b0}}, q_size});
  end
`endif

endmodule

// File: tb/tb_vx_fifo_share_arb.sv
// Directed bench: expected grants are hand-computed per cycle; each expected
// queue entry goes to a scoreboard that an independent monitor drains on pops.
import vx_fifo_share_pkg::*;

module tb_vx_fifo_share_arb;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
  logic         out_ready;
  logic [19:0]  req_count;
  logic [4:0]   size;

  int checks;
  int errors;
  logic [7:0] seq [4];
  share_entry_t sb [$];

  vx_fifo_share_arb #(
    .NUM_REQS(4), .DATAW(32), .SIZE(16), .MAX_PER_REQ(8), .OUT_REG(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ready (out_ready),
    .req_count (req_count),
    .size      (size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane payload: tag 0xA0, requester in byte 1, per-lane sequence in byte 0.
  always_comb begin
    req_data = '0;
    for (int i = 0; i < 4; i++) begin
      req_data[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 8) | 32'(seq[i]);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2id(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [4:0] cnt(input int i);
    return req_count[i*5 +: 5];
  endfunction

  // One cycle: drive, check grant mid-cycle, log the expected entry, cross the edge.
  task automatic cyc(input logic [3:0] v, input logic ordy, input logic [3:0] exp_rdy,
                     input string name);
    share_entry_t e;
    int id;
    req_valid = v;
    out_ready = ordy;
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp_rdy));
    id = oh2id(exp_rdy);
    if (exp_rdy != 4'b0) begin
      e.id   = 2'(id);
      e.data = 32'hA000_0000 | (32'(id) << 8) | 32'(seq[id]);
      sb.push_back(e);
      $display("grant id=%0d data=%08h", id, e.data);
    end
    @(posedge clk);
    #1;
    if (exp_rdy != 4'b0) seq[id] = seq[id] + 8'd1;
  endtask

  // Monitor: every accepted output entry is compared against the scoreboard.
  initial begin : monitor
    share_entry_t exp_e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got id=%0d data=%08h expected no entry", out_id, out_data);
        end else begin
          exp_e = sb.pop_front();
          $display("pop id=%0d data=%08h", out_id, out_data);
          chk("pop_id", 64'(out_id), 64'(exp_e.id));
          chk("pop_data", 64'(out_data), 64'(exp_e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) seq[i] = 8'd0;
    reset     = 1'b1;
    req_valid = 4'b1111;
    out_ready = 1'b0;

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_size", 64'(size), 64'd0);
    chk("rst_count", 64'(req_count), 64'd0);

    // Released, but the gate holds grants off until the next edge.
    reset     = 1'b0;
    req_valid = 4'b0001;
    #1;
    chk("gate_ready", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    @(posedge clk);
    #1;

    // Single requester, three pushes drained as they arrive.
    cyc(4'b0001, 1'b1, 4'b0001, "single_g0");
    chk("single_cnt0_a", 64'(cnt(0)), 64'd1);
    cyc(4'b0001, 1'b1, 4'b0001, "single_g1");
    cyc(4'b0001, 1'b1, 4'b0001, "single_g2");
    chk("single_cnt0_b", 64'(cnt(0)), 64'd1);
    cyc(4'b0000, 1'b1, 4'b0000, "single_idle");
    chk("single_cnt0_c", 64'(cnt(0)), 64'd0);
    chk("single_size", 64'(size), 64'd0);

    // Fairness: rr_ptr=1 after the last grant to 0.
    for (int k = 0; k < 8; k++) begin
      cyc(4'b1111, 1'b1, 4'b0001 << ((k + 1) % 4), "fair_grant");
    end
    cyc(4'b0000, 1'b1, 4'b0000, "fair_drain");
    chk("fair_size", 64'(size), 64'd0);

    // Cap: requester 2 alone, no draining.
    for (int k = 0; k < 8; k++) cyc(4'b0100, 1'b0, 4'b0100, "cap_grant");
    cyc(4'b0100, 1'b0, 4'b0000, "cap_block");
    chk("cap_size", 64'(size), 64'd8);
    chk("cap_cnt2", 64'(cnt(2)), 64'd8);
    cyc(4'b0100, 1'b1, 4'b0000, "cap_pop_cycle");
    cyc(4'b0100, 1'b0, 4'b0100, "cap_regrant");
    chk("cap_cnt2_b", 64'(cnt(2)), 64'd8);

    // Full: eligible 0,1,3 from rr_ptr=3 -> 3,0,1,3,0,1,3,0.
    cyc(4'b1111, 1'b0, 4'b1000, "full_g");
    cyc(4'b1111, 1'b0, 4'b0001, "full_g");
    cyc(4'b1111, 1'b0, 4'b0010, "full_g");
    cyc(4'b1111, 1'b0, 4'b1000, "full_g");
    cyc(4'b1111, 1'b0, 4'b0001, "full_g");
    cyc(4'b1111, 1'b0, 4'b0010, "full_g");
    cyc(4'b1111, 1'b0, 4'b1000, "full_g");
    cyc(4'b1111, 1'b0, 4'b0001, "full_g");
    chk("full_size", 64'(size), 64'd16);
    cyc(4'b1111, 1'b0, 4'b0000, "full_block");
    cyc(4'b1111, 1'b1, 4'b0000, "full_pop_nogrant");
    chk("full_size_b", 64'(size), 64'd15);
    cyc(4'b1111, 1'b0, 4'b0010, "full_after_pop");
    chk("full_size_c", 64'(size), 64'd16);

    // Drain seven ID-2 entries plus the 3 and 0 behind them.
    for (int k = 0; k < 9; k++) cyc(4'b0000, 1'b1, 4'b0000, "drain");
    chk("same_head_id", 64'(out_id), 64'd1);
    chk("same_cnt1_pre", 64'(cnt(1)), 64'd3);
    chk("same_size_pre", 64'(size), 64'd7);

    // Same-ID grant and pop in one cycle.
    cyc(4'b0010, 1'b1, 4'b0010, "same_grant");
    chk("same_cnt1", 64'(cnt(1)), 64'd3);
    chk("same_size", 64'(size), 64'd7);

    // Bring occupancy to 5, then reset asynchronously between edges.
    cyc(4'b0000, 1'b1, 4'b0000, "pre_rst_drain");
    cyc(4'b0000, 1'b1, 4'b0000, "pre_rst_drain");
    chk("pre_rst_size", 64'(size), 64'd5);
    req_valid = 4'b1111;
    out_ready = 1'b0;
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    chk("mid_rst_count", 64'(req_count), 64'd0);
    chk("mid_rst_size", 64'(size), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_gate_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    cyc(4'b1111, 1'b0, 4'b0001, "post_rst_g0");
    cyc(4'b1111, 1'b0, 4'b0010, "post_rst_g1");
    chk("post_rst_size", 64'(size), 64'd2);
    cyc(4'b0000, 1'b1, 4'b0000, "final_drain");
    cyc(4'b0000, 1'b1, 4'b0000, "final_drain");
    cyc(4'b0000, 1'b1, 4'b0000, "final_idle");
    chk("final_size", 64'(size), 64'd0);
    chk("final_valid", 64'(out_valid), 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
